// File: rtl/core_ctrl.sv
// core_ctrl: sequences one kij pass of weight load, activation execute and psum write-back into the core instruction word
module core_ctrl #(
    parameter int col = 8,
    parameter int row = 8,
    parameter int len_nij = 36,
    parameter int gap = 10,
    parameter logic [10:0] w_base = 11'h400
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  kij,
    input  logic        ofifo_valid,
    output logic [33:0] inst,
    output logic        busy,
    output logic        done,
    output logic        err
);
    typedef enum logic [3:0] {IDLE, W_L0, W_LD, GAP, A_L0, EXEC, DRAIN, O_RD, DONE} state_t;
    localparam logic [33:0] idle_w = 34'h1_800C_0000;
    localparam logic [15:0] t_wl0 = 16'(col);
    localparam logic [15:0] t_wld = 16'(col + row - 1);
    localparam logic [15:0] t_gap = 16'(gap - 1);
    localparam logic [15:0] t_al0 = 16'(len_nij);
    localparam logic [15:0] t_ex = 16'(len_nij - 1);
    localparam logic [10:0] nl = 11'(len_nij);
    state_t state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [10:0] n_q, n_d;
    logic [3:0] kij_q, kij_d;
    logic wr_q, wr_d;
    logic err_q, err_d;
    logic [33:0] inst_q, inst_d;
    logic rd;
    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q + 16'd1;
        n_d = n_q;
        kij_d = kij_q;
        wr_d = 1'b0;
        err_d = 1'b0;
        inst_d = idle_w;
        rd = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                err_d = start && (kij > 4'd8);
                if (start && kij <= 4'd8) begin
                    kij_d = kij;
                    state_d = W_L0;
                end
            end
            W_L0: begin
                inst_d[19] = ~(cnt_q < t_wl0);
                inst_d[17:7] = (cnt_q < t_wl0) ? w_base + cnt_q[10:0] : 11'd0;
                inst_d[2] = cnt_q != '0;
                if (cnt_q == t_wl0) begin
                    state_d = W_LD;
                    cnt_d = '0;
                end
            end
            W_LD: begin
                inst_d[3] = 1'b1;
                inst_d[0] = 1'b1;
                if (cnt_q == t_wld) begin
                    state_d = GAP;
                    cnt_d = '0;
                end
            end
            GAP: begin
                if (cnt_q == t_gap) begin
                    state_d = A_L0;
                    cnt_d = '0;
                end
            end
            A_L0: begin
                inst_d[19] = ~(cnt_q < t_al0);
                inst_d[17:7] = (cnt_q < t_al0) ? cnt_q[10:0] : 11'd0;
                inst_d[2] = cnt_q != '0;
                if (cnt_q == t_al0) begin
                    state_d = EXEC;
                    cnt_d = '0;
                end
            end
            EXEC: begin
                inst_d[3] = 1'b1;
                inst_d[1] = 1'b1;
                if (cnt_q == t_ex) begin
                    state_d = DRAIN;
                    cnt_d = '0;
                end
            end
            DRAIN: begin
                if (ofifo_valid) begin
                    state_d = O_RD;
                    cnt_d = '0;
                    n_d = '0;
                end
            end
            O_RD: begin
                // each read is written to pmem on the following cycle, so n already points past it
                rd = ofifo_valid && (n_q < nl);
                inst_d[6] = rd;
                n_d = n_q + {10'd0, rd};
                wr_d = rd;
                if (wr_q) begin
                    inst_d[32] = 1'b0;
                    inst_d[31] = 1'b0;
                    inst_d[30:20] = {7'd0, kij_q} * nl + n_q - 11'd1;
                end
                if (wr_q && n_q == nl) begin
                    state_d = DONE;
                    cnt_d = '0;
                end
            end
            DONE: begin
                state_d = IDLE;
                cnt_d = '0;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q <= '0;
            n_q <= '0;
            kij_q <= '0;
            wr_q <= 1'b0;
            err_q <= 1'b0;
            inst_q <= idle_w;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            n_q <= n_d;
            kij_q <= kij_d;
            wr_q <= wr_d;
            err_q <= err_d;
            inst_q <= inst_d;
        end
    end
    assign inst = inst_q;
    assign busy = state_q != IDLE;
    assign done = state_q == DONE;
    assign err = err_q;
endmodule

// File: tb/tb_core_ctrl.sv
// tb_core_ctrl: vector table, directed corner sequences and randomized passes against a phase-level reference model
module tb_core_ctrl;
    localparam int COL = 8;
    localparam int ROW = 8;
    localparam int LEN = 36;
    localparam int GAP = 10;
    localparam logic [10:0] WB = 11'h400;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic [3:0] kij = 4'd0;
    logic ofifo_valid = 1'b0;
    logic [33:0] inst;
    logic busy, done, err;
    int total = 0;
    int bad = 0;
    logic [33:0] pre[$];
    typedef struct {
        bit s;
        logic [3:0] k;
        bit e_err;
    } vec_t;
    vec_t tv[8];
    always #5 clk = ~clk;
    core_ctrl #(.col(COL), .row(ROW), .len_nij(LEN), .gap(GAP), .w_base(WB)) dut (
        .clk(clk), .reset(reset), .start(start), .kij(kij), .ofifo_valid(ofifo_valid),
        .inst(inst), .busy(busy), .done(done), .err(err)
    );
    function automatic logic [33:0] mk(bit xr, logic [10:0] xa, bit pw, logic [10:0] pa, bit ofr, bit l0r, bit l0w, bit ex, bit ld);
        logic [33:0] w;
        w = '0;
        w[32] = ~pw;
        w[31] = ~pw;
        w[30:20] = pa;
        w[19] = ~xr;
        w[18] = 1'b1;
        w[17:7] = xa;
        w[6] = ofr;
        w[3] = l0r;
        w[2] = l0w;
        w[1] = ex;
        w[0] = ld;
        return w;
    endfunction
    function automatic logic [33:0] idle();
        return mk(0, 11'd0, 0, 11'd0, 0, 0, 0, 0, 0);
    endfunction
    task automatic chk(input string nm, input logic [39:0] act, input logic [39:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    // mode: 0 ofifo_valid tied high, 1 toggling 1,0,1,0, 2 random; abort_at: tick index to pulse reset (0 = none)
    task automatic run_pass(input logic [3:0] k, input int mode, input bit hold, input int abort_at);
        int reads, writes, phase;
        bit pend, v, exp_rd, exp_wr, exp_done, fin;
        logic [10:0] base;
        base = 11'(k) * 11'(LEN);
        ofifo_valid = (mode == 0);
        start = 1'b1;
        kij = k;
        tick();
        chk("accept", {busy, done, err, inst}, {1'b1, 1'b0, 1'b0, idle()});
        if (!hold) begin
            start = 1'b0;
            kij = 4'($urandom_range(0, 15));
        end
        for (int i = 0; i < pre.size(); i++) begin
            tick();
            chk("prefix", {busy, done, err, inst}, {1'b1, 1'b0, 1'b0, pre[i]});
            if (abort_at == i + 1) begin
                #1 reset = 1'b0;
                #1 chk("async_rst", {busy, done, err, inst}, {1'b0, 1'b0, 1'b0, idle()});
                #1 reset = 1'b1;
                return;
            end
        end
        reads = 0;
        writes = 0;
        phase = 0;
        pend = 0;
        fin = 0;
        for (int c = 0; c < 400 && !fin; c++) begin
            v = (mode == 0) ? 1'b1 : (mode == 1) ? (c % 2 == 0) : 1'($urandom_range(0, 1));
            ofifo_valid = v;
            tick();
            exp_rd = (phase == 1) && v && (reads < LEN);
            exp_wr = pend;
            exp_done = (phase == 1) && pend && (writes == LEN - 1);
            chk("ord", {busy, done, err, inst},
                {1'b1, exp_done, 1'b0, mk(0, 11'd0, exp_wr, exp_wr ? base + 11'(writes) : 11'd0, exp_rd, 0, 0, 0, 0)});
            if (exp_done)
                chk("last_addr", {29'd0, inst[30:20]}, {29'd0, base + 11'(LEN - 1)});
            if (exp_wr) writes++;
            pend = exp_rd;
            reads += int'(exp_rd);
            if (phase == 0 && v) phase = 1;
            fin = exp_done;
        end
        if (!fin) begin
            total++;
            bad++;
            $display("FAIL ord_timeout: no done after 400 cycles, writes=%0d want %0d", writes, LEN);
        end
        ofifo_valid = 1'b0;
        tick();
        chk("post_idle", {busy, done, err, inst}, {1'b0, 1'b0, 1'b0, idle()});
    endtask
    initial begin
        for (int c = 0; c <= COL; c++) pre.push_back(mk(c < COL, c < COL ? WB + 11'(c) : 11'd0, 0, 11'd0, 0, 0, c >= 1, 0, 0));
        for (int c = 0; c < COL + ROW; c++) pre.push_back(mk(0, 11'd0, 0, 11'd0, 0, 1, 0, 0, 1));
        for (int c = 0; c < GAP; c++) pre.push_back(idle());
        for (int c = 0; c <= LEN; c++) pre.push_back(mk(c < LEN, c < LEN ? 11'(c) : 11'd0, 0, 11'd0, 0, 0, c >= 1, 0, 0));
        for (int c = 0; c < LEN; c++) pre.push_back(mk(0, 11'd0, 0, 11'd0, 0, 1, 0, 1, 0));
        tv[0] = '{1, 4'd9, 1};
        tv[1] = '{0, 4'd9, 0};
        tv[2] = '{1, 4'd15, 1};
        tv[3] = '{1, 4'd12, 1};
        tv[4] = '{0, 4'd0, 0};
        tv[5] = '{1, 4'd10, 1};
        tv[6] = '{0, 4'd3, 0};
        tv[7] = '{0, 4'd8, 0};
        #2 reset = 1'b0;
        #1 chk("reset", {busy, done, err, inst}, {1'b0, 1'b0, 1'b0, idle()});
        start = 1'b1;
        kij = 4'd4;
        repeat (3) tick();
        chk("reset_hold", {busy, done, err, inst}, {1'b0, 1'b0, 1'b0, idle()});
        start = 1'b0;
        reset = 1'b1;
        run_pass(4'd3, 0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            start = tv[i].s;
            kij = tv[i].k;
            tick();
            chk("vec", {busy, done, err, inst}, {1'b0, 1'b0, tv[i].e_err, idle()});
        end
        run_pass(4'd5, 1, 0, 0);
        run_pass(4'd2, 0, 0, 91);
        run_pass(4'd0, 0, 0, 0);
        run_pass(4'd8, 0, 1, 0);
        run_pass(4'd8, 2, 1, 0);
        start = 1'b0;
        for (int r = 0; r < 4; r++) run_pass(4'($urandom_range(0, 8)), 2, 0, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
